fp_norm_seq: RTL and testbench

- Multicycle normalize/pack stage downstream of the FP add datapath.
- Consumes a raw un-normalized sum (sign, larger exponent, 25-bit mantissa sum with carry bit) and normalizes it iteratively, one left shift per cycle.
- Produces an IEEE-754 single-precision result with zero/overflow/underflow flags.
- Uses valid/ready handshakes on both sides so it can sit between the adder and the multicycle FPU writeback.

---
 rtl/fp_norm_seq.sv | 164 ++++++++++++++++
 tb/tb_fp_norm_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_seq.sv
// Multicycle normalize/pack stage for the FP adder: takes a raw mantissa sum, shifts it left
// one bit per cycle until the hidden bit is set, then packs an IEEE-754 single with flags.
module fp_norm_seq #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned MANT_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W:0]   in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic              out_zero,
    output logic              out_overflow,
    output logic              out_underflow,
    output logic              busy
);

    // Two spare exponent bits absorb the carry increment without wrapping.
    localparam int unsigned XW = EXP_W + 2;
    localparam logic [XW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};
    localparam logic [XW-1:0] EXP_ONE = XW'(1);

    typedef enum logic [1:0] {StIdle, StCheck, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic              sign_q, sign_d;
    logic [XW-1:0]     exp_q, exp_d;
    logic [MANT_W:0]   mant_q, mant_d;
    logic              valid_q, valid_d;
    logic [31:0]       result_q, result_d;
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              do_pack;
    logic              do_unf;
    logic [XW-1:0]     pk_exp;
    logic [MANT_W:0]   pk_mant;

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        valid_d  = valid_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        do_pack  = 1'b0;
        do_unf   = 1'b0;
        pk_exp   = exp_q;
        pk_mant  = mant_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    sign_d  = in_sign;
                    exp_d   = {2'b00, in_exp};
                    mant_d  = in_mant;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (mant_q == '0) begin
                    result_d = 32'h0000_0000;
                    zero_d   = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = StDone;
                end else if (mant_q[MANT_W]) begin
                    pk_mant = mant_q >> 1;
                    pk_exp  = exp_q + 1'b1;
                    do_pack = 1'b1;
                end else if (mant_q[MANT_W-1]) begin
                    do_pack = 1'b1;
                end else if (exp_q <= EXP_ONE) begin
                    do_unf = 1'b1;
                end else begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (exp_q <= EXP_ONE) begin
                    do_unf = 1'b1;
                end else begin
                    mant_d = mant_q << 1;
                    exp_d  = exp_q - 1'b1;
                    // Bit just below the hidden position moves up this cycle: pack now.
                    if (mant_q[MANT_W-2]) begin
                        pk_mant = mant_d;
                        pk_exp  = exp_d;
                        do_pack = 1'b1;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    zero_d  = 1'b0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (do_pack) begin
            valid_d = 1'b1;
            state_d = StDone;
            if (pk_exp >= EXP_MAX) begin
                result_d = {sign_q, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
                ovf_d    = 1'b1;
            end else begin
                result_d = {sign_q, pk_exp[EXP_W-1:0], pk_mant[MANT_W-2:0]};
            end
        end

        if (do_unf) begin
            result_d = {sign_q, {(EXP_W+MANT_W-1){1'b0}}};
            unf_d    = 1'b1;
            valid_d  = 1'b1;
            state_d  = StDone;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign in_ready      = (state_q == StIdle);
    assign busy          = (state_q != StIdle);
    assign out_valid     = valid_q;
    assign out_result    = result_q;
    assign out_zero      = zero_q;
    assign out_overflow  = ovf_q;
    assign out_underflow = unf_q;

endmodule

// File: tb/tb_fp_norm_seq.sv
// Bench for fp_norm_seq: directed cases plus random operands checked against an
// arithmetic model of normalization (leading-one position, exponent budget, latency).
module tb_fp_norm_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [24:0] in_mant = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_overflow;
    logic        out_underflow;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    fp_norm_seq #(.EXP_W(8), .MANT_W(24)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_mant       (in_mant),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_zero      (out_zero),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Flags are {zero, overflow, underflow}; lat counts cycles after the accept edge.
    task automatic model(input logic s, input logic [7:0] e, input logic [24:0] m,
                         output logic [31:0] res, output logic [2:0] flg, output int lat);
        int p;
        int ex;
        int l;
        logic [24:0] sh;
        logic [22:0] frac;
        logic        pack;
        pack = 1'b0;
        ex   = int'(e);
        frac = '0;
        if (m == 0) begin
            res = 32'h0; flg = 3'b100; lat = 2;
        end else begin
            p = 24;
            while (!m[p]) p--;
            if (p == 24) begin
                ex = ex + 1; frac = m[23:1]; lat = 2; pack = 1'b1;
            end else if (p == 23) begin
                frac = m[22:0]; lat = 2; pack = 1'b1;
            end else if (ex <= 1) begin
                lat = 2; res = {s, 31'h0}; flg = 3'b001;
            end else begin
                l = 23 - p;
                if (l <= ex - 1) begin
                    sh = m << l; frac = sh[22:0]; ex = ex - l; lat = 2 + l; pack = 1'b1;
                end else begin
                    lat = (ex - 1) + 3; res = {s, 31'h0}; flg = 3'b001;
                end
            end
            if (pack) begin
                if (ex >= 255) begin
                    res = {s, 8'hFF, 23'h0}; flg = 3'b010;
                end else begin
                    res = {s, 8'(ex), frac}; flg = 3'b000;
                end
            end
        end
    endtask

    task automatic run_op(input logic s, input logic [7:0] e, input logic [24:0] m,
                          input int hold);
        logic [31:0] w_res;
        logic [2:0]  w_flg;
        int          w_lat;
        int          k;
        logic        ready_seen;
        logic [31:0] held;
        model(s, e, m, w_res, w_flg, w_lat);
        @(negedge clk);
        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sign  = 1'($urandom);
        in_exp   = 8'($urandom);
        in_mant  = 25'($urandom);
        k = 0;
        ready_seen = 1'b0;
        while (k < 64) begin
            @(negedge clk);
            k++;
            if (out_valid) break;
            if (in_ready) ready_seen = 1'b1;
        end
        if (!out_valid) begin
            check_eq("timeout_out_valid", 32'(out_valid), 32'd1);
            reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            return;
        end
        check_eq("latency", 32'(k), 32'(w_lat));
        check_eq("in_ready_while_busy", 32'(ready_seen), 32'd0);
        check_eq("result", out_result, w_res);
        check_eq("flags", 32'({out_zero, out_overflow, out_underflow}), 32'(w_flg));
        check_eq("busy_done", 32'(busy), 32'd1);
        held = w_res;
        repeat (hold) begin
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("hold_result", out_result, held);
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("release_valid", 32'(out_valid), 32'd0);
        check_eq("release_flags", 32'({out_zero, out_overflow, out_underflow}), 32'd0);
        check_eq("release_idle", 32'({busy, in_ready}), 32'b01);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] m;
        logic [7:0]  e;
        // Reset state, with in_valid asserted to show nothing is accepted.
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_result", out_result, 32'h0);
        check_eq("rst_flags", 32'({out_zero, out_overflow, out_underflow}), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_eq("post_rst_busy", 32'(busy), 32'd0);

        run_op(1'b0, 8'h80, 25'h0C00000, 0);
        check_eq("dir_norm", out_result, 32'h4040_0000);
        run_op(1'b0, 8'h7F, 25'h1000000, 1);
        check_eq("dir_carry", out_result, 32'h4000_0000);
        run_op(1'b0, 8'h7F, 25'h0200000, 0);
        check_eq("dir_lz2", out_result, 32'h3E80_0000);
        run_op(1'b1, 8'h55, 25'h0000000, 0);
        run_op(1'b0, 8'hFE, 25'h1000000, 0);
        check_eq("dir_ovf", out_result, 32'h7F80_0000);
        run_op(1'b1, 8'h02, 25'h0000001, 5);
        check_eq("dir_unf", out_result, 32'h8000_0000);

        // Reset in the middle of a long shift sequence.
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'h7F; in_mant = 25'h0000100;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("mid_shift_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_result", out_result, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        run_op(1'b1, 8'h90, 25'h0400000, 2);
        check_eq("after_rst", out_result, 32'hC780_0000);

        for (int i = 0; i < 150; i++) begin
            m = 25'($urandom);
            m = m >> $urandom_range(0, 25);
            e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom);
            if ($urandom_range(0, 7) == 0) e = 8'($urandom_range(252, 255));
            run_op(1'($urandom), e, m, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
